// File: rtl/cpu_program_loader.sv
// cpu_program_loader: host-side loader in front of the cpu top.
// Parses a 32-bit valid/ready command stream, writes IMEM/DMEM words through
// the external memory ports, then runs the cpu for a programmed number of
// cycles and pulses done.
// Optional build macro: LOADER_VERIFY_EN adds a read-back check after every
// memory write; a mismatch raises the sticky err and parks the loader in ERR.
module cpu_program_loader #(
  parameter int CNT_W       = 16,
  parameter int IMEM_DATA_W = 32,
  parameter int DMEM_DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_data,
  output logic [63:0]            addr_ext,
  output logic                   wen_ext,
  output logic                   ren_ext,
  output logic [IMEM_DATA_W-1:0] wdata_ext,
  input  logic [IMEM_DATA_W-1:0] rdata_ext,
  output logic [63:0]            addr_ext_2,
  output logic                   wen_ext_2,
  output logic                   ren_ext_2,
  output logic [DMEM_DATA_W-1:0] wdata_ext_2,
  input  logic [DMEM_DATA_W-1:0] rdata_ext_2,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [3:0] {
    S_HDR, S_ADDR, S_DATA_LO, S_DATA_HI, S_RUN, S_ERR, S_V_WR, S_V_RD, S_V_CMP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;         // words left to load / cycles left to run
  logic                     dmem_q, dmem_d;       // current load targets DMEM
  logic [63:0]              ptr_q, ptr_d;         // byte address of the next word
  logic [31:0]              lo_q, lo_d;           // DMEM low half waiting for its high half
  logic [63:0]              addr_q, addr_d;
  logic [IMEM_DATA_W-1:0]   wdata_q, wdata_d;
  logic                     wen_q, wen_d;
  logic [63:0]              addr2_q, addr2_d;
  logic [DMEM_DATA_W-1:0]   wdata2_q, wdata2_d;
  logic                     wen2_q, wen2_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     verify_fail;
  logic                     accept;

  assign s_ready     = (state_q == S_HDR) || (state_q == S_ADDR) ||
                       (state_q == S_DATA_LO) || (state_q == S_DATA_HI);
  assign accept      = s_valid && s_ready;
  assign busy        = (state_q != S_HDR);
  assign enable      = (state_q == S_RUN);
  assign addr_ext    = addr_q;
  assign wdata_ext   = wdata_q;
  assign wen_ext     = wen_q;
  assign addr_ext_2  = addr2_q;
  assign wdata_ext_2 = wdata2_q;
  assign wen_ext_2   = wen2_q;
  assign done        = done_q;
  // A read-back mismatch shows on err in the compare cycle itself; err_q keeps it.
  assign err         = err_q || verify_fail;

`ifndef LOADER_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^{rdata_ext, rdata_ext_2};
`endif

  // Next-state, stream decode, write issue and read-back compare.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_d      = dmem_q;
    ptr_d       = ptr_q;
    lo_d        = lo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    addr2_d     = addr2_q;
    wdata2_d    = wdata2_q;
    err_d       = err_q;
    wen_d       = 1'b0;
    wen2_d      = 1'b0;
    done_d      = 1'b0;
    ren_ext     = 1'b0;
    ren_ext_2   = 1'b0;
    verify_fail = 1'b0;

    unique case (state_q)
      S_HDR: begin
        if (accept) begin
          cnt_d = s_data[CNT_W-1:0];
          unique case (s_data[31:30])
            2'b00: begin dmem_d = 1'b0; state_d = S_ADDR; end
            2'b01: begin dmem_d = 1'b1; state_d = S_ADDR; end
            2'b10: if (s_data[CNT_W-1:0] != '0) state_d = S_RUN;
            default: begin err_d = 1'b1; state_d = S_ERR; end
          endcase
        end
      end
      S_ADDR: begin
        if (accept) begin
          ptr_d   = {32'd0, s_data};
          state_d = (cnt_q == '0) ? S_HDR : S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          if (dmem_q) begin
            lo_d    = s_data;
            state_d = S_DATA_HI;
          end else begin
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            wdata_d = s_data;
            ptr_d   = ptr_q + 64'd4;
            cnt_d   = cnt_q - CNT_ONE;
`ifdef LOADER_VERIFY_EN
            state_d = S_V_WR;
`else
            state_d = (cnt_q == CNT_ONE) ? S_HDR : S_DATA_LO;
`endif
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          wen2_d   = 1'b1;
          addr2_d  = ptr_q;
          wdata2_d = {s_data, lo_q};
          ptr_d    = ptr_q + 64'd8;
          cnt_d    = cnt_q - CNT_ONE;
`ifdef LOADER_VERIFY_EN
          state_d  = S_V_WR;
`else
          state_d  = (cnt_q == CNT_ONE) ? S_HDR : S_DATA_LO;
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          done_d  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_ERR: ;
`ifdef LOADER_VERIFY_EN
      S_V_WR: state_d = S_V_RD;
      S_V_RD: begin
        ren_ext   = !dmem_q;
        ren_ext_2 = dmem_q;
        state_d   = S_V_CMP;
      end
      S_V_CMP: begin
        verify_fail = dmem_q ? (rdata_ext_2 != wdata2_q) : (rdata_ext != wdata_q);
        if (verify_fail) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = (cnt_q == '0) ? S_HDR : S_DATA_LO;
        end
      end
`endif
      default: state_d = S_HDR;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_HDR;
      cnt_q    <= '0;
      dmem_q   <= 1'b0;
      ptr_q    <= '0;
      lo_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      addr2_q  <= '0;
      wdata2_q <= '0;
      wen2_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dmem_q   <= dmem_d;
      ptr_q    <= ptr_d;
      lo_q     <= lo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      addr2_q  <= addr2_d;
      wdata2_q <= wdata2_d;
      wen2_q   <= wen2_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Testbench for cpu_program_loader: directed stream vectors, a stream-level
// reference model compared every cycle, and literal checks on captured writes.
module tb_cpu_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [63:0] addr_ext, addr_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2 = '0;
  logic        enable, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_program_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable), .busy(busy), .done(done), .err(err)
  );

`ifdef LOADER_VERIFY_EN
  assign rdata_ext = 32'hFFFF_FFFF;
`else
  assign rdata_ext = 32'h0;
`endif

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model: meaning of each stream beat ----------------
  typedef enum {P_HDR, P_ADDR, P_LO, P_HI, P_RUN, P_DEAD} phase_e;
  phase_e      m_phase = P_HDR;
  bit          m_live = 0;
  bit          m_dmem;
  int          m_n, m_idx, m_left;
  logic [63:0] m_base;
  logic [31:0] m_lo;
  logic        e_ready = 0, e_busy = 0, e_enable = 0, e_done = 0, e_err = 0;
  logic        e_wen = 0, e_wen2 = 0;
  logic [63:0] e_addr = '0, e_addr2 = '0, e_wdata2 = '0;
  logic [31:0] e_wdata = '0;

  // Inputs change 1ns after posedge, so they are stable here.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_HDR; m_left = 0;
      e_done = 0; e_err = 0; e_wen = 0; e_wen2 = 0;
      e_addr = '0; e_addr2 = '0; e_wdata = '0; e_wdata2 = '0;
    end else begin
      e_wen = 0; e_wen2 = 0; e_done = 0;
      if (m_phase == P_RUN) begin
        m_left--;
        if (m_left == 0) begin e_done = 1; m_phase = P_HDR; end
      end else if (s_valid && e_ready) begin
        case (m_phase)
          P_HDR: begin
            m_n = int'(s_data[15:0]);
            case (s_data[31:30])
              2'd0, 2'd1: begin m_dmem = s_data[30]; m_phase = P_ADDR; end
              2'd2: if (m_n > 0) begin m_left = m_n; m_phase = P_RUN; end
              default: begin e_err = 1; m_phase = P_DEAD; end
            endcase
          end
          P_ADDR: begin
            m_base = 64'(s_data); m_idx = 0;
            m_phase = (m_n == 0) ? P_HDR : P_LO;
          end
          P_LO: begin
            if (m_dmem) begin m_lo = s_data; m_phase = P_HI; end
            else begin
              e_wen = 1; e_addr = m_base + 64'(4 * m_idx); e_wdata = s_data;
              m_idx++; m_phase = (m_idx == m_n) ? P_HDR : P_LO;
            end
          end
          P_HI: begin
            e_wen2 = 1; e_addr2 = m_base + 64'(8 * m_idx); e_wdata2 = {s_data, m_lo};
            m_idx++; m_phase = (m_idx == m_n) ? P_HDR : P_LO;
          end
          default: ;
        endcase
      end
    end
    e_ready  = (m_phase == P_HDR) || (m_phase == P_ADDR) || (m_phase == P_LO) || (m_phase == P_HI);
    e_busy   = (m_phase != P_HDR);
    e_enable = (m_phase == P_RUN);
    m_live   = 1;
  end

  // ---------------- monitor: per-cycle compare plus capture logs ----------------
  int          cyc = 0;
  logic [63:0] imem_addr_log[$], dmem_addr_log[$];
  logic [63:0] imem_data_log[$], dmem_data_log[$];
  int          en_cycles = 0, done_cnt = 0, en_first = -1, done_cyc = -1;
  int          wen_cnt = 0, wen_cyc = -1, err_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (wen_ext) begin
      imem_addr_log.push_back(addr_ext); imem_data_log.push_back(64'(wdata_ext));
      wen_cnt++;
      if (wen_cyc < 0) wen_cyc = cyc;
    end
    if (wen_ext_2) begin
      dmem_addr_log.push_back(addr_ext_2); dmem_data_log.push_back(wdata_ext_2);
    end
    if (enable) begin en_cycles++; if (en_first < 0) en_first = cyc; end
    if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
    if (err && err_cyc < 0) err_cyc = cyc;
`ifndef LOADER_VERIFY_EN
    if (m_live) begin
      check("s_ready", 64'(s_ready), 64'(e_ready));
      check("busy", 64'(busy), 64'(e_busy));
      check("enable", 64'(enable), 64'(e_enable));
      check("done", 64'(done), 64'(e_done));
      check("err", 64'(err), 64'(e_err));
      check("wen_ext", 64'(wen_ext), 64'(e_wen));
      check("wen_ext_2", 64'(wen_ext_2), 64'(e_wen2));
      check("ren_ext", 64'({ren_ext, ren_ext_2}), 64'd0);
      check("addr_ext", addr_ext, e_addr);
      check("wdata_ext", 64'(wdata_ext), 64'(e_wdata));
      check("addr_ext_2", addr_ext_2, e_addr2);
      check("wdata_ext_2", wdata_ext_2, e_wdata2);
    end
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [31:0] d);
    int waited = 0;
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        @(posedge clk); #1;
      end else begin
        waited++;
      end
    end
    check("beat_accept", 64'(ok), 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_data  = 32'hBAD0_BAD0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    imem_addr_log.delete(); imem_data_log.delete();
    dmem_addr_log.delete(); dmem_data_log.delete();
    en_cycles = 0; done_cnt = 0; en_first = -1; done_cyc = -1;
  endtask

  initial begin
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("reset_s_ready", 64'(s_ready), 64'd1);
    check("reset_busy", 64'({busy, enable, done, err, wen_ext, wen_ext_2}), 64'd0);
    check("reset_addr", addr_ext, 64'd0);
    @(posedge clk); #1;

`ifndef LOADER_VERIFY_EN
    // IMEM load, s_valid continuously high.
    clear_logs();
    beat(32'h0000_0003); beat(32'h0000_0000);
    beat(32'h0050_0093); beat(32'h00A0_0113); beat(32'h0020_81B3);
    idle(3);
    check("imem_count", 64'(imem_addr_log.size()), 64'd3);
    if (imem_addr_log.size() == 3) begin
      check("imem_a0", imem_addr_log[0], 64'h0); check("imem_d0", imem_data_log[0], 64'h0050_0093);
      check("imem_a1", imem_addr_log[1], 64'h4); check("imem_d1", imem_data_log[1], 64'h00A0_0113);
      check("imem_a2", imem_addr_log[2], 64'h8); check("imem_d2", imem_data_log[2], 64'h0020_81B3);
    end
    check("imem_idle_busy", 64'(busy), 64'd0);

    // DMEM load with a gap between the halves.
    clear_logs();
    beat(32'h4000_0001); beat(32'h0000_0010); beat(32'hDEAD_BEEF);
    idle(3);
    beat(32'h0123_4567);
    idle(3);
    check("dmem_count", 64'(dmem_addr_log.size()), 64'd1);
    if (dmem_addr_log.size() == 1) begin
      check("dmem_addr", dmem_addr_log[0], 64'h10);
      check("dmem_data", dmem_data_log[0], 64'h0123_4567_DEAD_BEEF);
    end

    // Empty load and address carry past 32 bits.
    clear_logs();
    beat(32'h0000_0000); beat(32'h0000_0100);
    beat(32'h0000_0002); beat(32'hFFFF_FFFC); beat(32'h1111_1111); beat(32'h2222_2222);
    idle(3);
    check("carry_count", 64'(imem_addr_log.size()), 64'd2);
    if (imem_addr_log.size() == 2) begin
      check("carry_a0", imem_addr_log[0], 64'h0000_0000_FFFF_FFFC);
      check("carry_a1", imem_addr_log[1], 64'h0000_0001_0000_0000);
    end

    // Run 5 cycles, then a zero-length run.
    clear_logs();
    beat(32'h8000_0005);
    idle(8);
    check("run_en_cycles", 64'(en_cycles), 64'd5);
    check("run_done_cnt", 64'(done_cnt), 64'd1);
    check("run_done_offset", 64'(done_cyc - en_first), 64'd5);
    clear_logs();
    beat(32'h8000_0000);
    idle(4);
    check("run0_enable", 64'(en_cycles), 64'd0);
    check("run0_done", 64'(done_cnt), 64'd0);

    // Illegal command, then reset recovery.
    beat(32'hC000_0000);
    idle(2);
    @(negedge clk);
    check("illegal_err", 64'(err), 64'd1);
    check("illegal_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    pulse_rst();
    @(negedge clk);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a 10-cycle run.
    clear_logs();
    beat(32'h8000_000A);
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_enable", 64'(enable), 64'd0);
    check("midrun_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    idle(12);
    check("midrun_en_cycles", 64'(en_cycles), 64'd3);
    check("midrun_done", 64'(done_cnt), 64'd0);
`else
    // Read-back against a memory that always returns all ones.
    beat(32'h0000_0003); beat(32'h0000_0000); beat(32'h0050_0093);
    idle(10);
    check("verify_err_offset", 64'(err_cyc - wen_cyc), 64'd2);
    check("verify_wen_cnt", 64'(wen_cnt), 64'd1);
    @(negedge clk);
    check("verify_err", 64'(err), 64'd1);
    check("verify_ready", 64'(s_ready), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
